// File: rtl/mini_core_pipe_ctrl_if.sv
// Hazard/handshake bundle between the mini-core pipeline and its stall/flush sequencer.
// The controller takes the slave side; the pipeline datapath takes the master side.
interface mini_core_pipe_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       RegSrc1Q101H;
  logic [4:0]       RegSrc2Q101H;
  logic             Uses1Q101H;
  logic             Uses2Q101H;
  logic             MemRdEnQ102H;
  logic [4:0]       RegDstQ102H;
  logic             BranchQ102H;
  logic             JumpQ102H;
  logic             BranchCondMetQ102H;
  logic             DMemReqQ103H;
  logic             DMemAckQ103H;
  logic             ReadyQ100H;
  logic             ReadyQ101H;
  logic             ReadyQ102H;
  logic             ReadyQ103H;
  logic             BubbleQ102H;
  logic             FlushQ101H;
  logic             SelNextPcQ102H;
  logic             MemTimeoutErr;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;
  logic [1:0]       State;

  modport slave (
    input  RegSrc1Q101H, RegSrc2Q101H, Uses1Q101H, Uses2Q101H, MemRdEnQ102H, RegDstQ102H,
    input  BranchQ102H, JumpQ102H, BranchCondMetQ102H, DMemReqQ103H, DMemAckQ103H,
    output ReadyQ100H, ReadyQ101H, ReadyQ102H, ReadyQ103H, BubbleQ102H, FlushQ101H,
    output SelNextPcQ102H, MemTimeoutErr, StallCnt, FlushCnt, State
  );

  modport master (
    output RegSrc1Q101H, RegSrc2Q101H, Uses1Q101H, Uses2Q101H, MemRdEnQ102H, RegDstQ102H,
    output BranchQ102H, JumpQ102H, BranchCondMetQ102H, DMemReqQ103H, DMemAckQ103H,
    input  ReadyQ100H, ReadyQ101H, ReadyQ102H, ReadyQ103H, BubbleQ102H, FlushQ101H,
    input  SelNextPcQ102H, MemTimeoutErr, StallCnt, FlushCnt, State
  );
endinterface

// File: rtl/mini_core_pipe_ctrl.sv
// Central stall/flush sequencer: per-stage Ready enables, Q102H bubbles, Q101H kill and PC redirect
// from load-use hazards, taken branches/jumps and data-memory wait states. Priority is
// MemStall > Taken > pending flush bubbles > LoadUse.
module mini_core_pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_W        = 16
) (
  input logic                 Clock,
  input logic                 Rst,
  mini_core_pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLdStall = 2'd1,
    StMemWait = 2'd2,
    StFlush   = 2'd3
  } state_e;

  localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] MemTo     = 8'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [2:0]       flush_left_q, flush_left_d;
  logic [7:0]       mem_wait_q, mem_wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_stall, load_use, taken, flush_inc;
  logic rdy_fetch, rdy_exe, bubble, flush, sel_pc;

  assign mem_stall = bus.DMemReqQ103H & ~bus.DMemAckQ103H;
  assign taken     = bus.JumpQ102H | (bus.BranchQ102H & bus.BranchCondMetQ102H);
  // LD_STALL never re-detects: the bubble it inserted now occupies Q102H.
  assign load_use  = bus.MemRdEnQ102H & (bus.RegDstQ102H != 5'd0) & (state_q != StLdStall) &
                     ((bus.Uses1Q101H & (bus.RegSrc1Q101H == bus.RegDstQ102H)) |
                      (bus.Uses2Q101H & (bus.RegSrc2Q101H == bus.RegDstQ102H)));

  // Next-state and hazard outputs, resolved in priority order.
  always_comb begin
    rdy_fetch    = 1'b1;
    rdy_exe      = 1'b1;
    bubble       = 1'b0;
    flush        = 1'b0;
    sel_pc       = 1'b0;
    flush_inc    = 1'b0;
    state_d      = StRun;
    flush_left_d = flush_left_q;
    mem_wait_d   = '0;
    err_d        = err_q;
    if (mem_stall) begin
      // Whole pipe frozen; redirect/load-use re-evaluated on the ack cycle.
      rdy_fetch  = 1'b0;
      rdy_exe    = 1'b0;
      state_d    = StMemWait;
      mem_wait_d = (mem_wait_q == MemTo) ? mem_wait_q : mem_wait_q + 8'd1;
      if (mem_wait_d == MemTo) err_d = 1'b1;
    end else if (taken) begin
      bubble    = 1'b1;
      flush     = 1'b1;
      sel_pc    = 1'b1;
      flush_inc = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d      = StFlush;
        flush_left_d = FlushInit;
      end else begin
        flush_left_d = 3'd0;
      end
    end else if (flush_left_q != 3'd0) begin
      // Keyed on the counter, not the state, so a flush frozen by MEM_WAIT resumes after ack.
      bubble       = 1'b1;
      flush        = 1'b1;
      flush_left_d = flush_left_q - 3'd1;
      state_d      = (flush_left_d != 3'd0) ? StFlush : StRun;
    end else if (load_use) begin
      rdy_fetch = 1'b0;
      bubble    = 1'b1;
      state_d   = StLdStall;
    end
    stall_cnt_d = stall_cnt_q;
    if (!rdy_fetch && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    flush_cnt_d = flush_cnt_q;
    if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // State, wait/flush counters, sticky error and performance counters.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state_q      <= StRun;
      flush_left_q <= 3'd0;
      mem_wait_q   <= 8'd0;
      err_q        <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      flush_left_q <= flush_left_d;
      mem_wait_q   <= mem_wait_d;
      err_q        <= err_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.ReadyQ100H     = rdy_fetch;
  assign bus.ReadyQ101H     = rdy_fetch;
  assign bus.ReadyQ102H     = rdy_exe;
  assign bus.ReadyQ103H     = rdy_exe;
  assign bus.BubbleQ102H    = bubble;
  assign bus.FlushQ101H     = flush;
  assign bus.SelNextPcQ102H = sel_pc;
  assign bus.MemTimeoutErr  = err_q;
  assign bus.StallCnt       = stall_cnt_q;
  assign bus.FlushCnt       = flush_cnt_q;
  assign bus.State          = state_q;

endmodule

// File: tb/tb_mini_core_pipe_ctrl.sv
// Directed bench for mini_core_pipe_ctrl with FLUSH_CYCLES=2, MEM_TIMEOUT=4, CNT_W=4.
module tb_mini_core_pipe_ctrl;

  logic Clock = 1'b0;
  logic Rst   = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  mini_core_pipe_ctrl_if #(.CNT_W(4)) bus ();

  mini_core_pipe_ctrl #(
    .FLUSH_CYCLES(2),
    .MEM_TIMEOUT (4),
    .CNT_W       (4)
  ) dut (
    .Clock(Clock),
    .Rst  (Rst),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  logic [3:0] rdy;
  logic [2:0] bfs;
  assign rdy = {bus.ReadyQ100H, bus.ReadyQ101H, bus.ReadyQ102H, bus.ReadyQ103H};
  assign bfs = {bus.BubbleQ102H, bus.FlushQ101H, bus.SelNextPcQ102H};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.RegSrc1Q101H       = 5'd0;
    bus.RegSrc2Q101H       = 5'd0;
    bus.Uses1Q101H         = 1'b0;
    bus.Uses2Q101H         = 1'b0;
    bus.MemRdEnQ102H       = 1'b0;
    bus.RegDstQ102H        = 5'd0;
    bus.BranchQ102H        = 1'b0;
    bus.JumpQ102H          = 1'b0;
    bus.BranchCondMetQ102H = 1'b0;
    bus.DMemReqQ103H       = 1'b0;
    bus.DMemAckQ103H       = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    Rst = 1'b1;
    #1;
    Rst = 1'b0;
    #1;
  endtask

  initial begin
    clear_inputs();
    #2;
    // Reset values
    check_eq("rst_state", bus.State, 2'd0);
    check_eq("rst_stall", bus.StallCnt, 4'd0);
    check_eq("rst_flush", bus.FlushCnt, 4'd0);
    check_eq("rst_err", bus.MemTimeoutErr, 1'b0);
    check_eq("rst_rdy", rdy, 4'hF);
    check_eq("rst_bfs", bfs, 3'b000);
    #6;
    Rst = 1'b0;
    tick();

    // Load-use: lw x5 in Q102H, add x6,x5,x1 in Q101H
    bus.MemRdEnQ102H = 1'b1; bus.RegDstQ102H = 5'd5;
    bus.RegSrc1Q101H = 5'd5; bus.Uses1Q101H = 1'b1;
    bus.RegSrc2Q101H = 5'd1; bus.Uses2Q101H = 1'b1;
    #1;
    check_eq("lu_rdy", rdy, 4'b0011);
    check_eq("lu_bfs", bfs, 3'b100);
    tick();
    clear_inputs();
    #1;
    check_eq("lu_state", bus.State, 2'd1);
    check_eq("lu_stallcnt", bus.StallCnt, 4'd1);
    check_eq("lu_after_rdy", rdy, 4'hF);
    check_eq("lu_after_bfs", bfs, 3'b000);
    tick();
    check_eq("lu_back_run", bus.State, 2'd0);

    // No stall when rd=x0 or rs not used; rs2 path does stall
    bus.MemRdEnQ102H = 1'b1; bus.RegDstQ102H = 5'd0;
    bus.RegSrc1Q101H = 5'd0; bus.Uses1Q101H = 1'b1;
    #1;
    check_eq("lu_x0_rdy", rdy, 4'hF);
    bus.RegDstQ102H = 5'd5; bus.RegSrc1Q101H = 5'd5; bus.Uses1Q101H = 1'b0;
    bus.RegSrc2Q101H = 5'd1; bus.Uses2Q101H = 1'b1;
    #1;
    check_eq("lu_nouse_rdy", rdy, 4'hF);
    bus.RegSrc2Q101H = 5'd5;
    #1;
    check_eq("lu_rs2_rdy", rdy, 4'b0011);
    clear_inputs();

    // Not-taken branch, then taken branch
    do_reset();
    bus.BranchQ102H = 1'b1;
    #1;
    check_eq("br_nt_bfs", bfs, 3'b000);
    bus.BranchCondMetQ102H = 1'b1;
    #1;
    check_eq("br_t_bfs", bfs, 3'b111);
    check_eq("br_t_rdy", rdy, 4'hF);
    tick();
    clear_inputs();
    #1;
    check_eq("br_fl_state", bus.State, 2'd3);
    check_eq("br_fl_bfs", bfs, 3'b110);
    check_eq("br_flushcnt", bus.FlushCnt, 4'd1);
    tick();
    check_eq("br_run_state", bus.State, 2'd0);
    check_eq("br_run_bfs", bfs, 3'b000);

    // MemStall with a pending taken jump: 3 frozen cycles, redirect on ack
    do_reset();
    bus.DMemReqQ103H = 1'b1; bus.JumpQ102H = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("ms_rdy", rdy, 4'h0);
      check_eq("ms_bfs", bfs, 3'b000);
      tick();
    end
    check_eq("ms_state", bus.State, 2'd2);
    check_eq("ms_stallcnt", bus.StallCnt, 4'd3);
    bus.DMemAckQ103H = 1'b1;
    #1;
    check_eq("ms_ack_bfs", bfs, 3'b111);
    check_eq("ms_ack_rdy", rdy, 4'hF);
    tick();
    clear_inputs();
    #1;
    check_eq("ms_fl_state", bus.State, 2'd3);
    check_eq("ms_flushcnt", bus.FlushCnt, 4'd1);
    check_eq("ms_err", bus.MemTimeoutErr, 1'b0);

    // MemStall inside FLUSH freezes the remaining bubble, which resumes after ack
    do_reset();
    bus.JumpQ102H = 1'b1;
    tick();
    clear_inputs();
    bus.DMemReqQ103H = 1'b1;
    #1;
    check_eq("fz_bfs", bfs, 3'b000);
    tick();
    check_eq("fz_state", bus.State, 2'd2);
    bus.DMemAckQ103H = 1'b1;
    #1;
    check_eq("fz_ack_bfs", bfs, 3'b110);
    tick();
    clear_inputs();
    #1;
    check_eq("fz_run", bus.State, 2'd0);
    check_eq("fz_run_bfs", bfs, 3'b000);

    // Timeout: error at 4th wait cycle, sticky past ack
    do_reset();
    bus.DMemReqQ103H = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_eq("to_err3", bus.MemTimeoutErr, 1'b0);
    tick();
    check_eq("to_err4", bus.MemTimeoutErr, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    check_eq("to_stallcnt", bus.StallCnt, 4'd10);
    bus.DMemAckQ103H = 1'b1;
    tick();
    clear_inputs();
    #1;
    check_eq("to_sticky", bus.MemTimeoutErr, 1'b1);
    check_eq("to_run", bus.State, 2'd0);

    // Reset mid-wait clears everything
    bus.DMemReqQ103H = 1'b1;
    tick();
    tick();
    Rst = 1'b1;
    #1;
    check_eq("mr_err", bus.MemTimeoutErr, 1'b0);
    check_eq("mr_state", bus.State, 2'd0);
    check_eq("mr_stallcnt", bus.StallCnt, 4'd0);
    Rst = 1'b0;
    clear_inputs();
    #1;

    // Counter saturation
    do_reset();
    bus.DMemReqQ103H = 1'b1;
    for (int i = 0; i < 21; i++) tick();
    check_eq("sat_stallcnt", bus.StallCnt, 4'd15);
    clear_inputs();
    bus.JumpQ102H = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check_eq("sat_flushcnt", bus.FlushCnt, 4'd15);
    check_eq("sat_stall_hold", bus.StallCnt, 4'd15);
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
